// File: rtl/nn_dense_layer.sv
// nn_dense_layer: one fully-connected fixed-point layer, loaded through a read port and
// evaluated serially at one MAC per cycle behind a 4-phase req/ack handshake.
module nn_dense_layer #(
   parameter int N_IN = 2,
   parameter int N_OUT = 2,
   parameter int FRAC = 4,
   parameter int RELU = 1,
   parameter logic [N_OUT*N_IN*8-1:0] WEIGHTS = {(N_OUT*N_IN){8'h10}},
   parameter logic [N_OUT*8-1:0] BIAS = '0,
   localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fill,
   input  logic                   req,
   output logic                   ack_layer,
   output logic                   in_rd,
   output logic [AW-1:0]          in_addr,
   input  logic signed [7:0]      in_data,
   output logic [N_OUT*8-1:0]     out_act
);
   localparam int ACCW = 16 + $clog2(N_IN + 1) + 1;
   localparam int CW = $clog2(N_IN + 1);
   localparam int JW = $clog2(N_OUT + 1);
   localparam logic [CW-1:0] LD_END = CW'(N_IN);
   localparam logic [AW-1:0] I_END = AW'(N_IN - 1);
   localparam logic [JW-1:0] J_END = JW'(N_OUT);
   localparam logic signed [ACCW-1:0] SAT_HI = 127;
   localparam logic signed [ACCW-1:0] SAT_LO = -128;

   typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, i_q, i_d;
   logic [JW-1:0] j_q, j_d, wr_j_q, wr_j_d, jj;
   logic rd_q, rd_d, wr_q, wr_d, ack_q, ack_d;
   logic signed [ACCW-1:0] acc_q, acc_d, base, sh, sat;
   logic signed [7:0] xbuf_q [N_IN];
   logic signed [7:0] xbuf_d [N_IN];
   logic [N_OUT*8-1:0] out_q, out_d;
   logic signed [7:0] w, b, y;
   logic signed [15:0] prod;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req && !fill) state_d = LOAD;
         LOAD: if (cnt_q == LD_END) state_d = MAC;
         MAC: if (j_q == J_END) state_d = DONE;
         DONE: if (!req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sync-read source: data for in_addr arrives one edge later and is captured on the next,
   // so xbuf is filled from a delayed copy of the strobe. j_q == N_OUT is the final write-back cycle.
   always_comb begin
      in_rd = (state_q == LOAD) && (cnt_q != LD_END);
      cnt_d = (state_q == LOAD) ? cnt_q + CW'(1) : '0;
      addr_d = (state_q == IDLE && state_d == LOAD) ? '0 :
               (in_rd && addr_q != I_END) ? addr_q + AW'(1) : addr_q;
      rd_d = in_rd;
      rd_addr_d = addr_q;
      xbuf_d = xbuf_q;
      if (rd_q) xbuf_d[rd_addr_q] = in_data;
      jj = (j_q == J_END) ? '0 : j_q;
      w = WEIGHTS[(int'(jj) * N_IN + int'(i_q)) * 8 +: 8];
      b = BIAS[int'(jj) * 8 +: 8];
      prod = w * xbuf_q[i_q];
      base = (i_q == '0) ? ({{(ACCW-8){b[7]}}, b} <<< FRAC) : acc_q;
      acc_d = (state_q == MAC && j_q != J_END) ? base + {{(ACCW-16){prod[15]}}, prod} : acc_q;
      i_d = (state_q == MAC && i_q != I_END) ? i_q + AW'(1) : '0;
      j_d = (state_q != MAC) ? '0 : (i_q == I_END) ? j_q + JW'(1) : j_q;
      wr_d = (state_q == MAC) && (j_q != J_END) && (i_q == I_END);
      wr_j_d = j_q;
      sh = acc_q >>> FRAC;
      sat = (sh > SAT_HI) ? SAT_HI : (sh < SAT_LO) ? SAT_LO : sh;
      y = (RELU != 0 && sat[7]) ? 8'sd0 : sat[7:0];
      out_d = out_q;
      if (wr_q) out_d[int'(wr_j_q) * 8 +: 8] = y;
      ack_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt_q <= '0;
         addr_q <= '0;
         rd_addr_q <= '0;
         rd_q <= 1'b0;
         i_q <= '0;
         j_q <= '0;
         wr_q <= 1'b0;
         wr_j_q <= '0;
         acc_q <= '0;
         xbuf_q <= '{default: '0};
         out_q <= '0;
         ack_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         rd_addr_q <= rd_addr_d;
         rd_q <= rd_d;
         i_q <= i_d;
         j_q <= j_d;
         wr_q <= wr_d;
         wr_j_q <= wr_j_d;
         acc_q <= acc_d;
         xbuf_q <= xbuf_d;
         out_q <= out_d;
         ack_q <= ack_d;
      end

   assign ack_layer = ack_q;
   assign in_addr = addr_q;
   assign out_act = out_q;
endmodule

// File: tb/tb_nn_dense_layer.sv
// tb_nn_dense_layer: directed checks of nn_dense_layer variants sharing one handshake and input buffer.
module tb_nn_dense_layer;
   logic clk = 1'b0, rst = 1'b0, fill = 1'b0, req = 1'b0;
   always #5 clk = ~clk;
   logic signed [7:0] mem [2];
   int n_cmp = 0, n_bad = 0;

   logic ack_a, rd_a, addr_a, ack_b, rd_b, addr_b, ack_r0, rd_r0, addr_r0;
   logic ack_s1, rd_s1, addr_s1, ack_s2, rd_s2, addr_s2, ack_bi, rd_bi, addr_bi;
   logic signed [7:0] dat_a = 0, dat_b = 0, dat_r0 = 0, dat_s1 = 0, dat_s2 = 0, dat_bi = 0;
   logic [15:0] out_a, out_r0, out_s1, out_s2, out_bi;
   logic [7:0] out_b;

   nn_dense_layer u_a (.clk(clk), .rst(rst), .fill(fill), .req(req), .ack_layer(ack_a),
      .in_rd(rd_a), .in_addr(addr_a), .in_data(dat_a), .out_act(out_a));
   nn_dense_layer #(.N_OUT(1)) u_b (.clk(clk), .rst(rst), .fill(1'b0), .req(ack_a), .ack_layer(ack_b),
      .in_rd(rd_b), .in_addr(addr_b), .in_data(dat_b), .out_act(out_b));
   nn_dense_layer #(.RELU(0)) u_r0 (.clk(clk), .rst(rst), .fill(fill), .req(req), .ack_layer(ack_r0),
      .in_rd(rd_r0), .in_addr(addr_r0), .in_data(dat_r0), .out_act(out_r0));
   nn_dense_layer #(.WEIGHTS({4{8'h7f}})) u_s1 (.clk(clk), .rst(rst), .fill(fill), .req(req),
      .ack_layer(ack_s1), .in_rd(rd_s1), .in_addr(addr_s1), .in_data(dat_s1), .out_act(out_s1));
   nn_dense_layer #(.WEIGHTS({4{8'h80}}), .RELU(0)) u_s2 (.clk(clk), .rst(rst), .fill(fill), .req(req),
      .ack_layer(ack_s2), .in_rd(rd_s2), .in_addr(addr_s2), .in_data(dat_s2), .out_act(out_s2));
   nn_dense_layer #(.BIAS(16'hF808), .RELU(0)) u_bi (.clk(clk), .rst(rst), .fill(fill), .req(req),
      .ack_layer(ack_bi), .in_rd(rd_bi), .in_addr(addr_bi), .in_data(dat_bi), .out_act(out_bi));

   // synchronous-read input buffers: data for a strobed address appears after the next edge
   always @(posedge clk) begin
      if (rd_a) dat_a <= mem[addr_a];
      if (rd_r0) dat_r0 <= mem[addr_r0];
      if (rd_s1) dat_s1 <= mem[addr_s1];
      if (rd_s2) dat_s2 <= mem[addr_s2];
      if (rd_bi) dat_bi <= mem[addr_bi];
      if (rd_b) dat_b <= addr_b ? out_a[15:8] : out_a[7:0];
   end

   task automatic compute(input logic signed [7:0] x0, input logic signed [7:0] x1);
      mem[0] = x0;
      mem[1] = x1;
      @(negedge clk);
      req = 1'b1;
      repeat (9) @(negedge clk);
   endtask

   task automatic release_req;
      req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ack_a, rd_a, addr_a} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctl: ack/rd/addr got %b want 000", {ack_a, rd_a, addr_a});
      end
      n_cmp++;
      if (out_a !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", out_a); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ack_a, rd_a} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: ack/rd got %b want 00", {ack_a, rd_a}); end
   endtask

   task automatic test_basic;
      mem[0] = 8'sd16;
      mem[1] = 8'sd0;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rd_a, addr_a} !== 2'b10) begin n_bad++; $display("FAIL load0: rd/addr got %b want 10", {rd_a, addr_a}); end
      @(negedge clk);
      n_cmp++;
      if ({rd_a, addr_a} !== 2'b11) begin n_bad++; $display("FAIL load1: rd/addr got %b want 11", {rd_a, addr_a}); end
      @(negedge clk);
      n_cmp++;
      if ({rd_a, addr_a} !== 2'b01) begin n_bad++; $display("FAIL load_end: rd/addr got %b want 01", {rd_a, addr_a}); end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b0) begin n_bad++; $display("FAIL ack_early: got %b want 0", ack_a); end
      @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b1) begin n_bad++; $display("FAIL ack_rise: got %b want 1", ack_a); end
      n_cmp++;
      if (out_a !== 16'h1010) begin n_bad++; $display("FAIL basic_out: got %h want 1010", out_a); end
      release_req;
      n_cmp++;
      if (ack_a !== 1'b0) begin n_bad++; $display("FAIL ack_fall: got %b want 0", ack_a); end
   endtask

   task automatic test_chain;
      int n = 0;
      while (ack_b !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ack_b !== 1'b1) begin n_bad++; $display("FAIL chain_ack: got %b want 1 within 20 cycles", ack_b); end
      n_cmp++;
      if (out_b !== 8'h20) begin n_bad++; $display("FAIL chain_out: got %h want 20", out_b); end
      @(negedge clk);
      n_cmp++;
      if (ack_b !== 1'b0) begin n_bad++; $display("FAIL chain_pulse: got %b want 0", ack_b); end
   endtask

   task automatic test_relu;
      compute(-8'sd32, 8'sd0);
      n_cmp++;
      if ({ack_a, out_a} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL relu_on: ack/out got %b/%h want 1/0000", ack_a, out_a); end
      n_cmp++;
      if ({ack_r0, out_r0} !== {1'b1, 16'hE0E0}) begin n_bad++; $display("FAIL relu_off: ack/out got %b/%h want 1/e0e0", ack_r0, out_r0); end
      release_req;
   endtask

   task automatic test_saturation;
      compute(8'sd127, 8'sd127);
      n_cmp++;
      if ({ack_s1, out_s1} !== {1'b1, 16'h7F7F}) begin n_bad++; $display("FAIL sat_hi: ack/out got %b/%h want 1/7f7f", ack_s1, out_s1); end
      n_cmp++;
      if ({ack_s2, out_s2} !== {1'b1, 16'h8080}) begin n_bad++; $display("FAIL sat_lo: ack/out got %b/%h want 1/8080", ack_s2, out_s2); end
      n_cmp++;
      if (out_a !== 16'h7F7F) begin n_bad++; $display("FAIL sat_default: got %h want 7f7f", out_a); end
      release_req;
   endtask

   task automatic test_bias;
      compute(8'sd0, 8'sd0);
      n_cmp++;
      if ({ack_bi, out_bi} !== {1'b1, 16'hF808}) begin n_bad++; $display("FAIL bias: ack/out got %b/%h want 1/f808", ack_bi, out_bi); end
      n_cmp++;
      if (out_a !== 16'h0000) begin n_bad++; $display("FAIL bias_zero: got %h want 0000", out_a); end
      release_req;
   endtask

   task automatic test_fill;
      int n = 0;
      mem[0] = 8'sd16;
      mem[1] = 8'sd0;
      @(negedge clk);
      fill = 1'b1;
      req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({rd_a, ack_a} !== 2'b00) begin n_bad++; $display("FAIL fill_block%0d: rd/ack got %b want 00", c, {rd_a, ack_a}); end
      end
      fill = 1'b0;
      while (ack_a !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n !== 9) begin n_bad++; $display("FAIL fill_latency: ack after %0d cycles want 9", n); end
      release_req;
   endtask

   task automatic test_hold;
      compute(8'sd16, 8'sd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (ack_a !== 1'b1) begin n_bad++; $display("FAIL hold%0d: ack got %b want 1", c, ack_a); end
      end
      release_req;
      n_cmp++;
      if (ack_a !== 1'b0) begin n_bad++; $display("FAIL hold_fall: ack got %b want 0", ack_a); end
   endtask

   task automatic test_pulse;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (7) @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b0) begin n_bad++; $display("FAIL pulse_early: ack got %b want 0", ack_a); end
      @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b1) begin n_bad++; $display("FAIL pulse_ack: ack got %b want 1", ack_a); end
      @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b0) begin n_bad++; $display("FAIL pulse_end: ack got %b want 0", ack_a); end
   endtask

   task automatic test_reset_mid;
      mem[0] = 8'sd16;
      mem[1] = 8'sd16;
      @(negedge clk);
      req = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (out_a !== 16'h1010) begin n_bad++; $display("FAIL mid_pre: out got %h want 1010", out_a); end
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if ({ack_a, rd_a, addr_a} !== 3'b000) begin n_bad++; $display("FAIL mid_ctl: ack/rd/addr got %b want 000", {ack_a, rd_a, addr_a}); end
      n_cmp++;
      if (out_a !== 16'h0000) begin n_bad++; $display("FAIL mid_out: got %h want 0000", out_a); end
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({ack_a, rd_a, out_a} !== 18'h0) begin n_bad++; $display("FAIL mid_idle%0d: ack/rd/out got %b/%b/%h want 0/0/0000", c, ack_a, rd_a, out_a); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_chain;
      test_relu;
      test_saturation;
      test_bias;
      test_fill;
      test_hold;
      test_pulse;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
